hall_call_dispatcher: RTL
=========================

Name: hall_call_dispatcher

Overview:
- Collects hall-call button presses (up/down per floor) into sticky pending registers.
- Serialises pending calls one at a time to the lift-selection logic (req_floor/req_direction -> selected_lift).
- Issues the winning call to Lift 1 or Lift 2 over a valid/ready assignment handshake, then clears the call.
- Sits between the hall button panel and the two car controllers, in front of the priority selector.

Parameters:
- NUM_FLOORS, 8, number of floors; must equal 2**FLOOR_W.
- FLOOR_W, 3, floor index width.
- RETRY_CYCLES, 4, back-off cycles after a query that returns no lift; range 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- hall_up  in  NUM_FLOORS  up-button pulse per floor; bit NUM_FLOORS-1 is ignored.
- hall_dn  in  NUM_FLOORS  down-button pulse per floor; bit 0 is ignored.
- req_valid  out  1  query to the selector is active.
- req_floor  out  FLOOR_W  floor under query.
- req_direction  out  1  direction under query; 1 = up, 0 = down.
- selected_lift  in  2  combinational selector answer: 00 none, 01 L1, 10 L2, 11 treated as none.
- assign_valid_L1 / assign_valid_L2  out  1  assignment offered to the lift.
- assign_ready_L1 / assign_ready_L2  in  1  lift accepts the assignment.
- assign_floor  out  FLOOR_W  floor of the offered assignment, shared by both lifts.
- assign_dir  out  1  direction of the offered assignment.
- pending_up / pending_dn  out  NUM_FLOORS  hall-lamp state of pending calls.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset values: all outputs 0, pending registers 0, scan pointer 0, FSM in IDLE.
  - Reset is honoured mid-operation: assign_valid_* and req_valid drop asynchronously and any in-flight call is lost.
- Pending registers: 16 call slots.
  - Slot i < 8 is the up call at floor i; slot i >= 8 is the down call at floor i-8.
  - A button bit high at a clock edge sets its slot.
  - A slot clears at the edge where its assignment handshake completes.
  - If set and clear occur on the same edge, set wins and the slot stays pending.
  - Repeated presses while a slot is pending have no additional effect.
  - Ignored bits (hall_up[7], hall_dn[0]) never set a slot.
- Scan: round-robin with wrap-around.
  - The first pending slot at or after the pointer (mod 16) is chosen.
  - On choosing, the pointer loads chosen+1 mod 16, so slot 15 wraps to 0.
- FSM states:
  - IDLE: if any slot is pending, latch the chosen slot into cur_floor/cur_dir and go to QUERY. Otherwise stay.
  - QUERY (exactly 1 cycle): req_valid=1, req_floor=cur_floor, req_direction=cur_dir. At the edge, sample selected_lift: 01 -> ISSUE1, 10 -> ISSUE2, 00/11 -> BACKOFF.
  - ISSUE1 / ISSUE2: assign_valid_Lx=1 with assign_floor/assign_dir = cur values, held stable until assign_ready_Lx. On the handshake edge, clear the slot and go to IDLE. The other lift's valid stays 0. Ready on the non-addressed lift is ignored.
  - BACKOFF: count RETRY_CYCLES cycles, then go to IDLE. The slot stays pending. The pointer has already advanced, so other calls get served first.
- Outputs in non-active states: req_* = 0 outside QUERY; assign_floor/assign_dir = 0 outside ISSUE*.
- Latency: press sampled at edge E0 -> pending lamp high after E0 -> QUERY after E1 -> ISSUE after E2. With ready already high, the handshake is at E3 and the lamp drops after E3.
- busy = (state != IDLE).

Test Plan:
- Reset, then hall_up[2] pulse, selected_lift=01, assign_ready_L1=1: assign_valid_L1 high after 2 edges following latch with floor=2, dir=1. pending_up[2] clears the cycle after the handshake.
- Press up[1], dn[5], up[6] in the same cycle, selector always 10, ready always 1: issue order is slot 1, slot 6, slot 13. Pointer ends at 14.
- Pending dn[3], selector returns 00: exactly 4 BACKOFF cycles, the call remains pending, and a re-query happens. Switching the selector to 01 then issues to L1.
- Assignment to L2 with ready held low for 10 cycles: valid, floor and dir stay stable for all 10 cycles. assign_ready_L1 pulses are ignored. Raising ready completes the handshake.
- hall_dn[4] pressed again on the handshake edge of the dn[4] call: pending_dn[4] stays 1 and the call is re-dispatched.
- Assert reset while in ISSUE1: assign_valid_L1 drops immediately, all pending registers clear, and the FSM is in IDLE. hall_up[7] and hall_dn[0] pulses never set pending.

Source files
------------

// File: rtl/hall_call_dispatcher.sv
// hall_call_dispatcher
//   Latches hall-call button presses into sticky pending slots, picks them one
//   at a time in round-robin order, asks the lift selector which car should
//   take the call, and offers the call to that car over a valid/ready handshake.
//   A call whose query returns no lift backs off and is retried later.
//
// Ports
//   clk, reset                : clock, asynchronous active-high reset
//   hall_up / hall_dn         : per-floor button pulses (top up / bottom down unused)
//   req_valid/req_floor/
//   req_direction             : query to the selector (direction 1 = up)
//   selected_lift             : selector answer, 01 = L1, 10 = L2, else none
//   assign_valid_L1/L2,
//   assign_ready_L1/L2        : assignment handshake per lift
//   assign_floor/assign_dir   : offered call, shared by both lifts
//   pending_up / pending_dn   : hall-lamp state
//   busy                      : dispatcher is not idle
module hall_call_dispatcher #(
  parameter int NUM_FLOORS   = 8,
  parameter int FLOOR_W      = 3,
  parameter int RETRY_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] hall_up,
  input  logic [NUM_FLOORS-1:0] hall_dn,
  output logic                  req_valid,
  output logic [FLOOR_W-1:0]    req_floor,
  output logic                  req_direction,
  input  logic [1:0]            selected_lift,
  output logic                  assign_valid_L1,
  output logic                  assign_valid_L2,
  input  logic                  assign_ready_L1,
  input  logic                  assign_ready_L2,
  output logic [FLOOR_W-1:0]    assign_floor,
  output logic                  assign_dir,
  output logic [NUM_FLOORS-1:0] pending_up,
  output logic [NUM_FLOORS-1:0] pending_dn,
  output logic                  busy
);

  // Slot index: low half are up calls, high half are down calls.
  localparam int NUM_SLOTS = 2 * NUM_FLOORS;
  localparam int SLOT_W    = FLOOR_W + 1;
  localparam logic [3:0] BACKOFF_LAST = 4'(RETRY_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    QUERY,
    ISSUE1,
    ISSUE2,
    BACKOFF
  } state_t;

  state_t                state, next_state;
  logic [NUM_SLOTS-1:0]  pending;
  logic [NUM_SLOTS-1:0]  set_mask, clr_mask;
  logic [NUM_FLOORS-1:0] up_mask, dn_mask;
  logic [SLOT_W-1:0]     scan_ptr, cur_slot, chosen_slot, scan_idx;
  logic                  any_pending, found, handshake;
  logic [3:0]            backoff_cnt;
  logic [FLOOR_W-1:0]    cur_floor;
  logic                  cur_dir;

  assign cur_floor   = cur_slot[FLOOR_W-1:0];
  assign cur_dir     = ~cur_slot[FLOOR_W];
  assign any_pending = |pending;
  assign handshake   = (state == ISSUE1 && assign_ready_L1) ||
                       (state == ISSUE2 && assign_ready_L2);

  // Button masks: no up call from the top floor, no down call from the bottom.
  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    up_mask                 = hall_up;
    up_mask[NUM_FLOORS-1]   = 1'b0;
    dn_mask                 = hall_dn;
    dn_mask[0]              = 1'b0;
    set_mask                = {dn_mask, up_mask};
    clr_mask                = '0;
    if (handshake) clr_mask[cur_slot] = 1'b1;
  end

  // Round-robin scan: first pending slot at or after the pointer. The slot
  // index is exactly SLOT_W bits wide, so the addition wraps modulo NUM_SLOTS.
  always_comb begin
    chosen_slot = '0;
    found       = 1'b0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      scan_idx = scan_ptr + SLOT_W'(k);
      if (!found && pending[scan_idx]) begin
        chosen_slot = scan_idx;
        found       = 1'b1;
      end
    end
  end

  // State register.
  // NOTE: the reset is asynchronous, so the valid outputs decoded from state
  // drop as soon as reset rises rather than at the next clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (any_pending) next_state = QUERY;
      QUERY: begin
        case (selected_lift)
          2'b01:   next_state = ISSUE1;
          2'b10:   next_state = ISSUE2;
          default: next_state = BACKOFF;
        endcase
      end
      ISSUE1:  if (assign_ready_L1) next_state = IDLE;
      ISSUE2:  if (assign_ready_L2) next_state = IDLE;
      BACKOFF: if (backoff_cnt == BACKOFF_LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Pending slots, scan pointer, current call and back-off counter.
  // Set is applied after clear, so a press on the handshake edge keeps the call.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending     <= '0;
      scan_ptr    <= '0;
      cur_slot    <= '0;
      backoff_cnt <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      if (state == IDLE && any_pending) begin
        cur_slot <= chosen_slot;
        scan_ptr <= chosen_slot + 1'b1;
      end
      if (state == BACKOFF) backoff_cnt <= backoff_cnt + 1'b1;
      else                  backoff_cnt <= '0;
    end
  end

  // Output decode.
  always_comb begin
    req_valid       = 1'b0;
    req_floor       = '0;
    req_direction   = 1'b0;
    assign_valid_L1 = 1'b0;
    assign_valid_L2 = 1'b0;
    assign_floor    = '0;
    assign_dir      = 1'b0;
    unique case (state)
      QUERY: begin
        req_valid     = 1'b1;
        req_floor     = cur_floor;
        req_direction = cur_dir;
      end
      ISSUE1: begin
        assign_valid_L1 = 1'b1;
        assign_floor    = cur_floor;
        assign_dir      = cur_dir;
      end
      ISSUE2: begin
        assign_valid_L2 = 1'b1;
        assign_floor    = cur_floor;
        assign_dir      = cur_dir;
      end
      default: ;
    endcase
  end

  assign busy       = (state != IDLE);
  assign pending_up = pending[NUM_FLOORS-1:0];
  assign pending_dn = pending[NUM_SLOTS-1:NUM_FLOORS];

endmodule
